raizing_colmix: RTL
===================

RAIZING_COLMIX -- requirements
Module: raizing_colmix

Interface
REQ-001 SHALL have input CLK96, 1 bit: 96 MHz system clock; all logic is on its rising edge.
REQ-002 SHALL have input RESET96, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have input PIXEL_CEN, 1 bit: pixel clock enable, one CLK96 cycle wide, at least 4 CLK96 cycles apart.
REQ-004 SHALL have inputs HB and VB, 1 bit each: horizontal and vertical blank, aligned with the pixel inputs.
REQ-005 SHALL have input EXTRATEXT_PIXEL, 11 bits: extra-text palette index; bits [3:0]=0 means transparent.
REQ-006 SHALL have input GP_PIXEL, 15 bits: GP9001 layer pixel; bits [14:11] are priority, bits [10:0] are the palette index, and bits [3:0]=0 means transparent.
REQ-007 SHALL have input LAYER_EN, 2 bits: bit0 enables extra-text, bit1 enables GP; a disabled layer is treated as transparent.
REQ-008 SHALL have input BACKDROP, 11 bits: palette index used when no layer is opaque.
REQ-009 SHALL have output PAL_ADDR, 11 bits: palette RAM read address.
REQ-010 SHALL have input PAL_DATA, 16 bits: palette word xBBBBBGGGGGRRRRR, valid 1 CLK96 after PAL_ADDR.
REQ-011 SHALL have outputs RED, GREEN, BLUE, 8 bits each: final colour.
REQ-012 SHALL have outputs HB_OUT and VB_OUT, 1 bit each: blanking delayed to match RGB.

Function
REQ-013 SHALL update all pipeline registers only on CLK96 edges where PIXEL_CEN=1, except the palette capture in REQ-017.
REQ-014 Stage 1 (PIXEL_CEN n) SHALL select the pixel as follows: extra-text if enabled and [3:0]≠0; else GP if enabled and [3:0]≠0; else BACKDROP.
REQ-015 Extra-text SHALL win over GP regardless of GP priority; GP priority bits SHALL be ignored for selection and SHALL be carried only to the debug output sel_layer.
REQ-016 Stage 1 SHALL register the selected index onto PAL_ADDR, register HB/VB into the stage-1 blank flags, and register a 2-bit sel_layer code (0=backdrop, 1=GP, 2=extra-text).
REQ-017 SHALL capture PAL_DATA into a holding register exactly 2 CLK96 cycles after a PIXEL_CEN pulse, using a 2-bit shift of PIXEL_CEN; no other cycle SHALL update the holding register.
REQ-018 Stage 2 (PIXEL_CEN n+1) SHALL convert the held word to RGB888, with each 5-bit channel c mapped to {c, c[4:2]}, and SHALL register RED, GREEN and BLUE.
REQ-019 Stage 2 SHALL register HB_OUT and VB_OUT from the stage-1 flags.
REQ-020 If either stage-1 blank flag is 1, stage 2 SHALL output RED=GREEN=BLUE=0.
REQ-021 Latency SHALL be exactly 2 PIXEL_CEN pulses from pixel or blank input to RGB and HB_OUT/VB_OUT.
REQ-022 The extra-text and GP inputs SHALL be sampled in the same PIXEL_CEN cycle, with no per-layer skew.
REQ-023 If PIXEL_CEN holds 0, all outputs SHALL hold their values.
REQ-024 Bit 15 of PAL_DATA SHALL be ignored.
REQ-025 A LAYER_EN change SHALL take effect from the next PIXEL_CEN.
REQ-026 A PIXEL_CEN arriving while a capture is pending SHALL be a stimulus violation (the spacing rule in REQ-003) and is not required to be handled.

Reset
REQ-027 While RESET96=1, PAL_ADDR, RED, GREEN, BLUE, the holding register, sel_layer and the PIXEL_CEN shift SHALL be 0.
REQ-028 While RESET96=1, HB_OUT and VB_OUT SHALL be 1.
REQ-029 Reset asserted mid-line SHALL discard in-flight pixels.
REQ-030 After RESET96 deasserts, the first valid RGB SHALL appear on the 2nd PIXEL_CEN; the 1st PIXEL_CEN after deassertion SHALL output blanked black.

Verification
REQ-031 Stimulus: EXTRATEXT_PIXEL=0x805, GP_PIXEL=0x7ABC, LAYER_EN=3, palette[0x805]=0x7FFF. Required response: PAL_ADDR=0x805, then RGB=FF,FF,FF two PIXEL_CENs after input.
REQ-032 Stimulus: EXTRATEXT_PIXEL=0x800 (transparent), GP_PIXEL index 0x123, palette[0x123]=0x001F. Required response: RGB=FF,00,00 (red), sel_layer=1.
REQ-033 Stimulus: both layers transparent, BACKDROP=0x010, palette[0x010]=0x4210. Required response: RGB=84,84,84, sel_layer=0.
REQ-034 Stimulus: LAYER_EN=2 with opaque extra-text 0x805 and GP index 0x123. Required response: PAL_ADDR=0x123.
REQ-035 Stimulus: HB=1 with opaque pixels present. Required response: RGB=0 and HB_OUT=1 two PIXEL_CENs later; HB_OUT falls 2 PIXEL_CENs after HB falls.
REQ-036 Stimulus: RESET96 pulsed mid-line for 3 CLK96 cycles. Required response: outputs 0 and blanks 1 immediately (asynchronously); first valid pixel on the 2nd PIXEL_CEN after release.

Source files
------------

// File: rtl/raizing_colmix.sv
// Colour mixer: picks extra-text / GP / backdrop index, looks it up in palette RAM, expands to RGB888.
// Latency: 2 PIXEL_CEN pulses from pixel/blank input to RED/GREEN/BLUE and HB_OUT/VB_OUT.
// Backpressure: none; PIXEL_CEN paces the pipe and outputs hold while it is low.
module raizing_colmix (
    input  logic        CLK96,
    input  logic        RESET96,
    input  logic        PIXEL_CEN,
    input  logic        HB,
    input  logic        VB,
    input  logic [10:0] EXTRATEXT_PIXEL,
    input  logic [14:0] GP_PIXEL,
    input  logic [1:0]  LAYER_EN,
    input  logic [10:0] BACKDROP,
    output logic [10:0] PAL_ADDR,
    input  logic [15:0] PAL_DATA,
    output logic [7:0]  RED,
    output logic [7:0]  GREEN,
    output logic [7:0]  BLUE,
    output logic        HB_OUT,
    output logic        VB_OUT,
    output logic [1:0]  sel_layer
);

    localparam logic [1:0] SEL_BACKDROP = 2'd0;
    localparam logic [1:0] SEL_GP       = 2'd1;
    localparam logic [1:0] SEL_TEXT     = 2'd2;

    logic        text_opaque;
    logic        gp_opaque;
    logic [10:0] sel_index;
    logic [1:0]  sel_code;

    logic        hb_s1;
    logic        vb_s1;
    logic [1:0]  cen_shift;
    logic [15:0] pal_hold;

    // 5-bit channel to 8-bit by replicating the top bits into the low bits
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    // Layer select: extra-text beats GP unconditionally; GP priority bits play no part
    always_comb begin
        text_opaque = LAYER_EN[0] && (EXTRATEXT_PIXEL[3:0] != 4'd0);
        gp_opaque   = LAYER_EN[1] && (GP_PIXEL[3:0] != 4'd0);
        sel_index   = BACKDROP;
        sel_code    = SEL_BACKDROP;
        if (text_opaque) begin
            sel_index = EXTRATEXT_PIXEL;
            sel_code  = SEL_TEXT;
        end else if (gp_opaque) begin
            sel_index = GP_PIXEL[10:0];
            sel_code  = SEL_GP;
        end
    end

    // Stage 1: palette address, layer code and blanking, advanced on the pixel enable.
    // Stage-1 blanks reset to 1 so the first pixel after reset comes out blanked black.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            PAL_ADDR  <= 11'd0;
            sel_layer <= SEL_BACKDROP;
            hb_s1     <= 1'b1;
            vb_s1     <= 1'b1;
        end else if (PIXEL_CEN) begin
            PAL_ADDR  <= sel_index;
            sel_layer <= sel_code;
            hb_s1     <= HB;
            vb_s1     <= VB;
        end
    end

    // Palette capture two CLK96 after the enable, once the RAM word for PAL_ADDR has settled
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            cen_shift <= 2'b00;
            pal_hold  <= 16'd0;
        end else begin
            cen_shift <= {cen_shift[0], PIXEL_CEN};
            if (cen_shift[1]) begin
                pal_hold <= PAL_DATA;
            end
        end
    end

    // Stage 2: colour expansion with blanking forced to black; bit 15 of the palette word is unused
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            RED    <= 8'd0;
            GREEN  <= 8'd0;
            BLUE   <= 8'd0;
            HB_OUT <= 1'b1;
            VB_OUT <= 1'b1;
        end else if (PIXEL_CEN) begin
            HB_OUT <= hb_s1;
            VB_OUT <= vb_s1;
            if (hb_s1 || vb_s1) begin
                RED   <= 8'd0;
                GREEN <= 8'd0;
                BLUE  <= 8'd0;
            end else begin
                RED   <= expand5(pal_hold[4:0]);
                GREEN <= expand5(pal_hold[9:5]);
                BLUE  <= expand5(pal_hold[14:10]);
            end
        end
    end

endmodule
